input_capture_unit: RTL and testbench
=====================================

# input_capture_unit

Parametrised operator-input front end. It synchronises and debounces a bank of push-buttons and captures switch values into N signed operand registers. It emits a gated one-cycle `start` pulse and cycles a multi-value mode selector. It sits between board I/O and the arithmetic core, which consumes `operands`, `mode` and `start` and returns `busy`.

## Interface
- `DATA_W`, 8: operand and switch width; operands are signed two's complement.
- `NUM_OPS`, 2: number of operand registers and load buttons (≥1).
- `DEBOUNCE_CYCLES`, 4: consecutive stable cycles needed to accept a button change; 0 bypasses the debounce counter (synchroniser kept).
- `NUM_MODES`, 2: number of mode values (≥2); `MODE_W = max(1, clog2(NUM_MODES))`.
- `REQUIRE_ALL_VALID`, 1: when 1, `start` fires only if every operand has been loaded since the last accepted start.
- `clk`  in  1  rising-edge clock, the only clock.
- `reset`  in  1  synchronous, active-low reset, sampled on `clk`.
- `switches`  in  DATA_W  raw switch bank.
- `btn_load`  in  NUM_OPS  raw load buttons; bit i loads operand i.
- `btn_start`  in  1  raw start button.
- `btn_mode`  in  1  raw mode-advance button.
- `busy`  in  1  core busy; blocks loads, starts and mode changes.
- `operands`  out  NUM_OPS*DATA_W  operand i at `[i*DATA_W +: DATA_W]`.
- `operand_valid`  out  NUM_OPS  bit i set once operand i has been loaded.
- `start`  out  1  one-cycle accepted-start pulse.
- `start_rejected`  out  1  one-cycle pulse when a start press is dropped.
- `mode`  out  MODE_W  current mode, 0..NUM_MODES-1.

## Operation
- Each button (NUM_OPS+2 total) has a 2-flop synchroniser, a debounce counter and a registered stable level.
- Debounce counter:
  - Clears whenever the synchronised level equals the stable level.
  - Otherwise it increments.
  - When it reaches DEBOUNCE_CYCLES, the stable level flips and the counter clears.
  - A bounce shorter than DEBOUNCE_CYCLES never changes the stable level.
- Press event = stable 0→1; release event = stable 1→0. Events are registered, one cycle wide.
- Load: a press event on `btn_load[i]` with `busy`=0 writes `switches`, as sampled on that edge, into operand i and sets `operand_valid[i]`. Simultaneous presses load every selected operand with the same value. A reload overwrites the operand.
- Start: a press event on `btn_start` is accepted when `busy`=0 and (`REQUIRE_ALL_VALID`=0 or `operand_valid` is all ones, using the pre-edge register value).
  - Accepted: `start`=1 for one cycle and `operand_valid` clears to 0; operand values are retained.
  - Not accepted: `start_rejected`=1 for one cycle. A dropped start is never queued.
- Start and the final load coinciding on the same edge: the load completes, and the start is rejected when `REQUIRE_ALL_VALID`=1.
- Mode: a release event on `btn_mode` with `busy`=0 advances `mode` by 1, wrapping from NUM_MODES-1 to 0. The event is ignored while `busy`=1.
- Width rules:
  - Debounce counters are wide enough for DEBOUNCE_CYCLES with no overflow.
  - `mode` never holds a value ≥ NUM_MODES, including non-power-of-two NUM_MODES.

## Timing
- Reset (`reset`=0 at an edge) clears the following to 0: all outputs, synchroniser flops, stable levels, counters, event flops. This applies mid-debounce and mid-operation.
- A button held through reset release produces a press event as if newly pressed.
- Latency: raw level first sampled high at edge 1 → synchroniser output high after edge 2 → stable high after edge DEBOUNCE_CYCLES+2 → event/`start` high after edge DEBOUNCE_CYCLES+3, low after the next edge.
- With defaults, `start` is visible 7 edges after the press.
- Operand and `operand_valid` update on the same edge that `start` would assert.
- `busy` is sampled on the edge the event is consumed; a press whose event lands while `busy`=1 is lost.
- Holding a button generates exactly one press event; a new one requires a debounced release.

## Test plan
- Reset, then press `btn_load[0]` with switches=0x85 and `btn_load[1]` with switches=0x12, then `btn_start` → operands = 0x1285, valid=2'b11; `start` is high for exactly 1 cycle, 7 edges after the start press; valid clears to 0.
- Press `btn_start` with only operand 0 loaded → `start_rejected` pulses once, `start` stays 0; with `REQUIRE_ALL_VALID`=0 the same press gives `start`.
- Bounce `btn_start` high for 3 cycles, low, high for 3 cycles (DEBOUNCE_CYCLES=4) → no event; a clean 10-cycle hold → exactly one `start`.
- NUM_MODES=3: five release events on `btn_mode` → `mode` sequence 1,2,0,1,2; a release while `busy`=1 leaves `mode` unchanged.
- `busy`=1 during a load press with switches=0x7F → operand and valid unchanged.
- Assert `reset`=0 mid-debounce with `btn_load[0]` held → all outputs 0 next cycle; after release of reset, the held button loads the operand at edge DEBOUNCE_CYCLES+3.

Source files
------------

// File: rtl/input_capture_unit.sv
// Operator-input front end: synchronises and debounces the button bank, captures
// switch values into signed operand registers, and issues gated start / mode events.
module input_capture_unit #(
  parameter int DATA_W            = 8,
  parameter int NUM_OPS           = 2,
  parameter int DEBOUNCE_CYCLES   = 4,
  parameter int NUM_MODES         = 2,
  parameter int REQUIRE_ALL_VALID = 1,
  parameter int MODE_W            = (NUM_MODES > 2) ? $clog2(NUM_MODES) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_W-1:0]         switches,
  input  logic [NUM_OPS-1:0]        btn_load,
  input  logic                      btn_start,
  input  logic                      btn_mode,
  input  logic                      busy,
  output logic [NUM_OPS*DATA_W-1:0] operands,
  output logic [NUM_OPS-1:0]        operand_valid,
  output logic                      start,
  output logic                      start_rejected,
  output logic [MODE_W-1:0]         mode
);

  // Button bank ordering: loads in [NUM_OPS-1:0], then start, then mode.
  localparam int NB    = NUM_OPS + 2;
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic [NB-1:0] raw;
  logic [NB-1:0] sync1_q, sync2_q;
  logic [NB-1:0] stable;
  logic [NB-1:0] prev_q;
  logic [NB-1:0] press, release_ev;

  assign raw = {btn_mode, btn_start, btn_load};

  // Stage 0: two-flop synchroniser and previous-stable-level tracker
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      prev_q  <= stable;
    end
  end

  // Stage 1: debounce; with no debounce the synchroniser output is the stable level
  generate
    if (DEBOUNCE_CYCLES == 0) begin : gen_bypass
      assign stable = sync2_q;
    end else begin : gen_debounce
      logic [NB-1:0]    stable_q;
      logic [CNT_W-1:0] cnt_q [NB];

      always_ff @(posedge clk) begin
        if (!reset) begin
          stable_q <= '0;
          for (int b = 0; b < NB; b++) cnt_q[b] <= '0;
        end else begin
          for (int b = 0; b < NB; b++) begin
            if (sync2_q[b] == stable_q[b]) begin
              cnt_q[b] <= '0;
            end else if (cnt_q[b] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
              stable_q[b] <= ~stable_q[b];
              cnt_q[b]    <= '0;
            end else begin
              cnt_q[b] <= cnt_q[b] + CNT_W'(1);
            end
          end
        end
      end

      assign stable = stable_q;
    end
  endgenerate

  assign press      = stable & ~prev_q;
  assign release_ev = ~stable & prev_q;

  logic signed [DATA_W-1:0] ops_q [NUM_OPS];
  logic [NUM_OPS-1:0]       valid_q, valid_d;
  logic [NUM_OPS-1:0]       load_mask;
  logic                     start_q, rej_q;
  logic [MODE_W-1:0]        mode_q, mode_d;
  logic                     start_ev, accept, mode_ev;

  assign load_mask = press[NUM_OPS-1:0] & {NUM_OPS{~busy}};
  assign start_ev  = press[NUM_OPS];
  assign mode_ev   = release_ev[NUM_OPS+1] & ~busy;
  // The all-valid test uses the pre-edge register, so a coinciding final load cannot enable it.
  assign accept    = start_ev & ~busy & ((REQUIRE_ALL_VALID == 0) || (&valid_q));

  always_comb begin
    valid_d = (accept ? '0 : valid_q) | load_mask;
    mode_d  = mode_q;
    if (mode_ev) begin
      mode_d = (mode_q == MODE_W'(NUM_MODES - 1)) ? '0 : mode_q + MODE_W'(1);
    end
  end

  // Stage 2: event consumption into operand, valid, pulse and mode registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_OPS; i++) ops_q[i] <= '0;
      valid_q <= '0;
      start_q <= 1'b0;
      rej_q   <= 1'b0;
      mode_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_OPS; i++) begin
        if (load_mask[i]) ops_q[i] <= $signed(switches);
      end
      valid_q <= valid_d;
      start_q <= accept;
      rej_q   <= start_ev & ~accept;
      mode_q  <= mode_d;
    end
  end

  generate
    for (genvar g = 0; g < NUM_OPS; g++) begin : gen_pack
      assign operands[g*DATA_W +: DATA_W] = ops_q[g];
    end
  endgenerate

  assign operand_valid  = valid_q;
  assign start          = start_q;
  assign start_rejected = rej_q;
  assign mode           = mode_q;

endmodule

// File: tb/tb_input_capture_unit.sv
// Bench for input_capture_unit: two instances (strict and relaxed start gating)
// checked against a window-based reference model plus directed vector tables.
module tb_input_capture_unit;

  localparam int DW = 8;
  localparam int NO = 2;
  localparam int DB = 4;
  localparam int NB = NO + 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] switches = '0;
  logic [NO-1:0] btn_load = '0;
  logic          btn_start = 1'b0;
  logic          btn_mode = 1'b0;
  logic          busy = 1'b0;

  logic [NO*DW-1:0] ops_a, ops_b;
  logic [NO-1:0]    val_a, val_b;
  logic             st_a, st_b, rj_a, rj_b;
  logic [1:0]       mode_a;
  logic [0:0]       mode_b;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  input_capture_unit #(.DATA_W(DW), .NUM_OPS(NO), .DEBOUNCE_CYCLES(DB),
                       .NUM_MODES(3), .REQUIRE_ALL_VALID(1)) dut_a (
    .clk(clk), .reset(reset), .switches(switches), .btn_load(btn_load),
    .btn_start(btn_start), .btn_mode(btn_mode), .busy(busy),
    .operands(ops_a), .operand_valid(val_a), .start(st_a),
    .start_rejected(rj_a), .mode(mode_a));

  input_capture_unit #(.DATA_W(DW), .NUM_OPS(NO), .DEBOUNCE_CYCLES(DB),
                       .NUM_MODES(2), .REQUIRE_ALL_VALID(0)) dut_b (
    .clk(clk), .reset(reset), .switches(switches), .btn_load(btn_load),
    .btn_start(btn_start), .btn_mode(btn_mode), .busy(busy),
    .operands(ops_b), .operand_valid(val_b), .start(st_b),
    .start_rejected(rj_b), .mode(mode_b));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: a button's stable level flips once the last DB synchronised
  // samples all disagree with it; the core applies the load/start/mode rules.
  typedef struct {
    logic [NO*DW-1:0] ops;
    logic [NO-1:0]    val;
    logic             st;
    logic             rj;
    int               mode;
  } core_t;

  core_t         mc [2];
  int            nmodes [2] = '{3, 2};
  int            rav [2] = '{1, 0};
  logic [NB-1:0] m_d1 = '0, m_d2 = '0, m_stab = '0, m_prev = '0;
  logic [NB-1:0] m_win [DB];

  always @(posedge clk) begin
    logic [NB-1:0] raw, pr, rl, nstab;
    bit            all_diff;
    if (!reset) begin
      m_d1 = '0; m_d2 = '0; m_stab = '0; m_prev = '0;
      for (int j = 0; j < DB; j++) m_win[j] = '0;
      for (int k = 0; k < 2; k++) begin
        mc[k].ops = '0; mc[k].val = '0; mc[k].st = 1'b0; mc[k].rj = 1'b0; mc[k].mode = 0;
      end
    end else begin
      raw = {btn_mode, btn_start, btn_load};
      pr  = m_stab & ~m_prev;
      rl  = ~m_stab & m_prev;
      for (int j = DB - 1; j > 0; j--) m_win[j] = m_win[j-1];
      m_win[0] = m_d2;
      nstab = m_stab;
      for (int b = 0; b < NB; b++) begin
        all_diff = 1'b1;
        for (int j = 0; j < DB; j++) if (m_win[j][b] == m_stab[b]) all_diff = 1'b0;
        if (all_diff) nstab[b] = ~m_stab[b];
      end
      m_prev = m_stab; m_stab = nstab; m_d2 = m_d1; m_d1 = raw;
      for (int k = 0; k < 2; k++) begin
        mc[k].st = 1'b0; mc[k].rj = 1'b0;
        if (pr[NO]) begin
          if (!busy && (rav[k] == 0 || (&mc[k].val))) begin
            mc[k].st = 1'b1; mc[k].val = '0;
          end else begin
            mc[k].rj = 1'b1;
          end
        end
        for (int i = 0; i < NO; i++) begin
          if (pr[i] && !busy) begin
            mc[k].ops[i*DW +: DW] = switches;
            mc[k].val[i] = 1'b1;
          end
        end
        if (rl[NO+1] && !busy) mc[k].mode = (mc[k].mode + 1) % nmodes[k];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_ops_a",  64'(ops_a),  64'(mc[0].ops));
      check("model_val_a",  64'(val_a),  64'(mc[0].val));
      check("model_st_a",   64'(st_a),   64'(mc[0].st));
      check("model_rj_a",   64'(rj_a),   64'(mc[0].rj));
      check("model_mode_a", 64'(mode_a), 64'(mc[0].mode));
      check("model_ops_b",  64'(ops_b),  64'(mc[1].ops));
      check("model_val_b",  64'(val_b),  64'(mc[1].val));
      check("model_st_b",   64'(st_b),   64'(mc[1].st));
      check("model_rj_b",   64'(rj_b),   64'(mc[1].rj));
      check("model_mode_b", 64'(mode_b), 64'(mc[1].mode));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(input int b, input logic v);
    if (b < NO) btn_load[b] = v;
    else if (b == NO) btn_start = v;
    else btn_mode = v;
  endtask

  task automatic press_btn(input int b, input int hold);
    set_btn(b, 1'b1);
    cyc(hold);
    set_btn(b, 1'b0);
    cyc(10);
  endtask

  task automatic watch(input int b, input int hold, output int first,
                       output int na, output int nb, output int ra, output int rb);
    first = -1; na = 0; nb = 0; ra = 0; rb = 0;
    set_btn(b, 1'b1);
    for (int e = 1; e <= 22; e++) begin
      @(negedge clk);
      if (st_a) begin na++; if (first < 0) first = e; end
      if (st_b) nb++;
      if (rj_a) ra++;
      if (rj_b) rb++;
      if (e == hold) set_btn(b, 1'b0);
    end
  endtask

  typedef struct {
    logic [NO-1:0]    mask;
    logic [DW-1:0]    sw;
    logic             bsy;
    logic [NO*DW-1:0] eops;
    logic [NO-1:0]    eval;
  } vec_t;

  vec_t tbl [5];
  int   exp_mode_a [5] = '{1, 2, 0, 1, 2};
  int   exp_mode_b [5] = '{1, 0, 1, 0, 1};

  initial begin
    int first, na, nb, ra, rb;

    tbl[0] = '{2'b01, 8'h7F, 1'b1, 16'h1285, 2'b00};
    tbl[1] = '{2'b01, 8'h33, 1'b0, 16'h1233, 2'b01};
    tbl[2] = '{2'b10, 8'hAA, 1'b0, 16'hAA33, 2'b11};
    tbl[3] = '{2'b11, 8'h5C, 1'b0, 16'h5C5C, 2'b11};
    tbl[4] = '{2'b10, 8'h80, 1'b0, 16'h805C, 2'b11};

    reset = 1'b0;
    cyc(2);
    chk_en = 1'b1;
    cyc(1);
    check("reset_ops", 64'(ops_a), 64'h0);
    check("reset_out", 64'({val_a, st_a, rj_a, mode_a}), 64'h0);
    reset = 1'b1;
    cyc(2);

    switches = 8'h85; press_btn(0, 8);
    switches = 8'h12; press_btn(1, 8);
    check("load_ops", 64'(ops_a), 64'h1285);
    check("load_valid", 64'(val_a), 64'h3);
    watch(NO, 8, first, na, nb, ra, rb);
    check("start_latency", 64'(first), 64'd7);
    check("start_pulses", 64'(na), 64'd1);
    check("start_valid_clear", 64'(val_a), 64'h0);
    check("start_ops_kept", 64'(ops_a), 64'h1285);

    for (int v = 0; v < 5; v++) begin
      switches = tbl[v].sw;
      busy = tbl[v].bsy;
      btn_load = tbl[v].mask;
      cyc(8);
      btn_load = '0;
      cyc(10);
      busy = 1'b0;
      check($sformatf("tbl%0d_ops_a", v), 64'(ops_a), 64'(tbl[v].eops));
      check($sformatf("tbl%0d_val_a", v), 64'(val_a), 64'(tbl[v].eval));
      check($sformatf("tbl%0d_ops_b", v), 64'(ops_b), 64'(tbl[v].eops));
      check($sformatf("tbl%0d_val_b", v), 64'(val_b), 64'(tbl[v].eval));
    end

    watch(NO, 8, first, na, nb, ra, rb);
    check("full_start_a", 64'(na), 64'd1);
    check("full_start_b", 64'(nb), 64'd1);
    switches = 8'h21; press_btn(0, 8);
    watch(NO, 8, first, na, nb, ra, rb);
    check("partial_start_a", 64'(na), 64'd0);
    check("partial_rej_a", 64'(ra), 64'd1);
    check("partial_start_b", 64'(nb), 64'd1);
    check("partial_rej_b", 64'(rb), 64'd0);
    check("partial_val_a", 64'(val_a), 64'h1);

    btn_start = 1'b1; cyc(3); btn_start = 1'b0; cyc(2);
    btn_start = 1'b1; cyc(3); btn_start = 1'b0;
    na = 0; ra = 0; nb = 0;
    for (int e = 0; e < 15; e++) begin
      @(negedge clk);
      if (st_a || st_b) na++;
      if (rj_a || rj_b) ra++;
    end
    check("bounce_start", 64'(na), 64'd0);
    check("bounce_rej", 64'(ra), 64'd0);
    switches = 8'hF0; press_btn(1, 8);
    watch(NO, 10, first, na, nb, ra, rb);
    check("clean_start_a", 64'(na), 64'd1);
    check("clean_start_b", 64'(nb), 64'd1);

    for (int k = 0; k < 5; k++) begin
      press_btn(NO + 1, 6);
      check($sformatf("mode%0d_a", k), 64'(mode_a), 64'(exp_mode_a[k]));
      check($sformatf("mode%0d_b", k), 64'(mode_b), 64'(exp_mode_b[k]));
    end
    busy = 1'b1; press_btn(NO + 1, 6); busy = 1'b0;
    check("mode_busy_a", 64'(mode_a), 64'd2);
    check("mode_busy_b", 64'(mode_b), 64'd1);

    switches = 8'h4D; btn_load[0] = 1'b1;
    cyc(3);
    reset = 1'b0;
    cyc(1);
    check("midreset_a", 64'({ops_a, val_a, st_a, rj_a, mode_a}), 64'h0);
    check("midreset_b", 64'({ops_b, val_b, st_b, rj_b, mode_b}), 64'h0);
    reset = 1'b1;
    first = -1;
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      if (val_a[0] && first < 0) first = e;
    end
    check("held_reload_edge", 64'(first), 64'd7);
    check("held_reload_ops", 64'(ops_a), 64'h004D);
    btn_load = '0;
    cyc(10);

    for (int c = 0; c < 600; c++) begin
      switches = DW'($urandom);
      busy = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 249) != 0);
      for (int b = 0; b < NB; b++) begin
        if ($urandom_range(0, 5) == 0) begin
          if (b < NO) set_btn(b, ~btn_load[b]);
          else if (b == NO) set_btn(b, ~btn_start);
          else set_btn(b, ~btn_mode);
        end
      end
      cyc(1);
    end
    reset = 1'b1; busy = 1'b0; btn_load = '0; btn_start = 1'b0; btn_mode = 1'b0;
    cyc(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
